mac_mdc_out_collector: RTL and testbench



---
 rtl/mac_mdc_out_collector_if.sv | 15 +
 rtl/mac_mdc_out_collector.sv | 205 ++++++++++++++++++++
 tb/tb_mac_mdc_out_collector.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_mdc_out_collector_if.sv
// Valid/ready stream bundle (data + byte strobes) shared by the engine, collector and store streamer.
// The source drives valid/data/strb; the sink drives ready.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
) ();
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;

    modport source (output valid, data, strb, input ready);
    modport sink   (input valid, data, strb, output ready);
endinterface

// File: rtl/mac_mdc_out_collector.sv
// Terminates the MAC MDC engine's d stream: takes len beats per job through a small circular buffer,
// counts emitted beats and pulses done_o after the last one. Option: MAC_MDC_COLLECTOR_CHECKSUM_EN adds csum_o.
module mac_mdc_out_collector #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 32,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clear_i,
    input  logic                   start_i,
    input  logic [CNT_WIDTH-1:0]   len_i,
    hwpe_stream_intf_stream.sink   d_i,
    hwpe_stream_intf_stream.source q_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [CNT_WIDTH-1:0]   cnt_o,
    output logic                   err_o
`ifdef MAC_MDC_COLLECTOR_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0]  csum_o
`endif
);

    localparam int unsigned STRB_W   = DATA_WIDTH / 8;
    localparam int unsigned PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PW:0] OCC_FULL = (PW+1)'(FIFO_DEPTH);

    generate
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("mac_mdc_out_collector: FIFO_DEPTH must be a power of two and >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                r_state;
    logic                  r_dready;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;
    logic                  r_vld_idle;
    logic [CNT_WIDTH-1:0]  r_len;
    logic [CNT_WIDTH-1:0]  r_acc;
    logic [CNT_WIDTH-1:0]  r_cnt;

    logic [DATA_WIDTH-1:0] r_mem_data [FIFO_DEPTH];
    logic [STRB_W-1:0]     r_mem_strb [FIFO_DEPTH];
    logic [PW-1:0]         r_wptr;
    logic [PW-1:0]         r_rptr;
    logic [PW:0]           r_occ;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_empty;
    logic [PW:0]           w_occ_nxt;
    logic [CNT_WIDTH-1:0]  w_acc_inc;
    logic [CNT_WIDTH-1:0]  w_cnt_inc;
    logic [DATA_WIDTH-1:0] w_head_data;

    assign w_empty     = (r_occ == '0);
    assign w_push      = d_i.valid & r_dready;
    assign w_pop       = q_o.ready & ~w_empty;
    assign w_occ_nxt   = r_occ + (PW+1)'(w_push) - (PW+1)'(w_pop);
    assign w_acc_inc   = (&r_acc) ? r_acc : r_acc + CNT_WIDTH'(1);
    assign w_cnt_inc   = (&r_cnt) ? r_cnt : r_cnt + CNT_WIDTH'(1);
    assign w_head_data = r_mem_data[r_rptr];

    assign d_i.ready = r_dready;
    assign q_o.valid = ~w_empty;
    assign q_o.data  = w_head_data;
    assign q_o.strb  = r_mem_strb[r_rptr];
    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign cnt_o     = r_cnt;
    assign err_o     = r_err;

    // Entries are zeroed on reset/clear so an empty buffer presents data=0 and strb=0.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_data[i] <= '0;
                r_mem_strb[i] <= '0;
            end
            r_wptr <= '0;
            r_rptr <= '0;
            r_occ  <= '0;
        end else if (clear_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_data[i] <= '0;
                r_mem_strb[i] <= '0;
            end
            r_wptr <= '0;
            r_rptr <= '0;
            r_occ  <= '0;
        end else begin
            if (w_push) begin
                r_mem_data[r_wptr] <= d_i.data;
                r_mem_strb[r_wptr] <= d_i.strb;
                r_wptr             <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            r_occ <= w_occ_nxt;
        end
    end

    // Ready, busy and done are registered from next-state values, so d_i.ready never sees q_o.ready combinationally.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_dready   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_vld_idle <= 1'b0;
            r_len      <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
        end else if (clear_i) begin
            r_state    <= S_IDLE;
            r_dready   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_vld_idle <= 1'b0;
            r_len      <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
        end else begin
            if (w_pop) begin
                r_cnt <= w_cnt_inc;
            end

            // Beats offered with no job armed: one stray cycle is tolerated, two in a row is an overrun.
            if (r_state == S_IDLE && d_i.valid) begin
                r_vld_idle <= 1'b1;
                if (r_vld_idle) begin
                    r_err <= 1'b1;
                end
            end else begin
                r_vld_idle <= 1'b0;
            end

            unique case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_len <= len_i;
                        r_acc <= '0;
                        r_cnt <= '0;
                        if (len_i != '0) begin
                            r_state  <= S_RUN;
                            r_busy   <= 1'b1;
                            r_dready <= 1'b1;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    r_dready <= (w_occ_nxt != OCC_FULL);
                    if (w_push) begin
                        r_acc <= w_acc_inc;
                        if (w_acc_inc == r_len) begin
                            r_state  <= S_DRAIN;
                            r_dready <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_occ_nxt == '0) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef MAC_MDC_COLLECTOR_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] r_csum;

    assign csum_o = r_csum;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_csum <= '0;
        end else if (clear_i) begin
            r_csum <= '0;
        end else if (r_state == S_IDLE && start_i) begin
            r_csum <= '0;
        end else if (w_pop) begin
            r_csum <= r_csum ^ w_head_data;
        end
    end
`endif

endmodule

// File: tb/tb_mac_mdc_out_collector.sv
// Randomized and directed bench for mac_mdc_out_collector against a queue-based job model.
module tb_mac_mdc_out_collector;
    localparam int DW    = 32;
    localparam int CW    = 32;
    localparam int DEPTH = 2;

    logic          clk   = 1'b0;
    logic          rst   = 1'b0;
    logic          clear = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] len   = '0;
    logic          busy, done, err;
    logic [CW-1:0] cnt;
`ifdef MAC_MDC_COLLECTOR_CHECKSUM_EN
    logic [DW-1:0] csum;
`endif

    hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) d_if ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) q_if ();

    mac_mdc_out_collector #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (clear),
        .start_i (start),
        .len_i   (len),
        .d_i     (d_if),
        .q_o     (q_if),
        .busy_o  (busy),
        .done_o  (done),
        .cnt_o   (cnt),
        .err_o   (err)
`ifdef MAC_MDC_COLLECTOR_CHECKSUM_EN
        ,
        .csum_o  (csum)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model: a job is a count of beats flowing through a queue
    typedef struct packed {logic [DW-1:0] d; logic [3:0] s;} beat_t;
    beat_t         m_q[$];
    bit            m_busy = 0, m_done = 0, m_err = 0, m_fresh = 1, m_push_last = 0;
    int            m_vcnt = 0;
    logic [CW-1:0] m_len = '0, m_acc = '0, m_cnt = '0;
    logic [DW-1:0] m_csum = '0;
    bit            s_rdy, s_vld, s_psh, s_pop;

    function automatic bit m_idle();
        return !m_busy && !m_done;
    endfunction

    function automatic bit m_ready();
        return m_busy && (m_acc < m_len) && (m_q.size() < DEPTH);
    endfunction

    task automatic m_reset();
        m_q.delete();
        m_busy = 0; m_done = 0; m_err = 0; m_fresh = 1; m_push_last = 0; m_vcnt = 0;
        m_len = '0; m_acc = '0; m_cnt = '0; m_csum = '0;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst || clear) begin
            m_reset();
        end else begin
            s_rdy = m_ready();
            s_vld = m_q.size() > 0;
            s_psh = d_if.valid && s_rdy;
            s_pop = q_if.ready && s_vld;
            if (m_idle() && d_if.valid) begin
                m_vcnt++;
                if (m_vcnt >= 2) m_err = 1;
            end else begin
                m_vcnt = 0;
            end
            if (s_pop) begin
                m_csum = m_csum ^ m_q[0].d;
                void'(m_q.pop_front());
                if (m_cnt != '1) m_cnt++;
            end
            if (s_psh) begin
                m_q.push_back('{d_if.data, d_if.strb});
                m_fresh = 0;
                if (m_acc != '1) m_acc++;
            end
            m_push_last = s_psh;
            if (m_done) begin
                m_done = 0;
            end else if (m_busy) begin
                if (m_acc == m_len && m_q.size() == 0) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end else if (start) begin
                m_len = len; m_acc = '0; m_cnt = '0; m_csum = '0;
                if (len == '0) m_done = 1;
                else m_busy = 1;
            end
        end
    end

    // ---------------- per-cycle compare and observation log
    logic [DW-1:0] obs_d[$];
    int            obs_c[$];
    int            d_hs = 0, done_n = 0, done_cyc = -1;
    logic [CW-1:0] cnt_at_done = '0;
    logic [DW-1:0] csum_at_done = '0;

    always @(negedge clk) begin
        chk("d_ready", 64'(d_if.ready), 64'(m_ready()));
        chk("q_valid", 64'(q_if.valid), 64'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            chk("q_data", 64'(q_if.data), 64'(m_q[0].d));
            chk("q_strb", 64'(q_if.strb), 64'(m_q[0].s));
        end else if (m_fresh) begin
            chk("q_data_zero", 64'(q_if.data), 64'(0));
            chk("q_strb_zero", 64'(q_if.strb), 64'(0));
        end
        chk("busy", 64'(busy), 64'(m_busy));
        chk("done", 64'(done), 64'(m_done));
        chk("cnt", 64'(cnt), 64'(m_cnt));
        chk("err", 64'(err), 64'(m_err));
`ifdef MAC_MDC_COLLECTOR_CHECKSUM_EN
        chk("csum", 64'(csum), 64'(m_csum));
        if (done) csum_at_done = csum;
`endif
        if (q_if.valid && q_if.ready) begin
            obs_d.push_back(q_if.data);
            obs_c.push_back(cyc);
        end
        if (d_if.valid && d_if.ready) d_hs++;
        if (done) begin
            done_n++;
            done_cyc    = cyc;
            cnt_at_done = cnt;
        end
    end

    // ---------------- stimulus
    int            start_cyc = 0, hs_at_hold = 0;
    logic [DW-1:0] qdata_at_hold = '0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!m_idle() && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) chk("wait_idle_timeout", 64'(1), 64'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_q_valid"}, 64'(q_if.valid), 64'(0));
        chk({tag, "_d_ready"}, 64'(d_if.ready), 64'(0));
        chk({tag, "_busy"},    64'(busy),       64'(0));
        chk({tag, "_done"},    64'(done),       64'(0));
        chk({tag, "_cnt"},     64'(cnt),        64'(0));
        chk({tag, "_err"},     64'(err),        64'(0));
        chk({tag, "_q_data"},  64'(q_if.data),  64'(0));
        chk({tag, "_q_strb"},  64'(q_if.strb),  64'(0));
    endtask

    // Runs one job: vp/rp are valid/ready percentages, q_ready held low for the first `hold` cycles,
    // seq gives data 1..l, mid re-pulses start with len 2, abort_at>0 asserts rst after that many beats.
    task automatic run_job(input int l, input int vp, input int rp, input int hold,
                           input bit seq, input bit mid, input int abort_at);
        int sent = 0;
        int k = 0;
        bit done_seen = 0;
        wait_idle();
        obs_d.delete(); obs_c.delete();
        d_hs = 0; done_n = 0; done_cyc = -1;
        start = 1; len = CW'(l); start_cyc = cyc;
        tick();
        start = 0;
        while (k < 600) begin
            if (m_push_last) begin
                sent++;
                d_if.valid = 0;
            end
            if (abort_at > 0 && sent == abort_at) begin
                d_if.valid = 0;
                #2 rst = 1;
                #1 check_reset_outputs("async_rst");
                tick();
                rst = 0;
                q_if.ready = 0;
                return;
            end
            if (done_seen) break;
            if (m_done) done_seen = 1;
            if (!d_if.valid && sent < l && m_busy && $urandom_range(99) < vp) begin
                d_if.valid = 1;
                d_if.data  = seq ? DW'(sent + 1) : $urandom;
                d_if.strb  = 4'($urandom);
            end
            if (hold > 0 && k == hold) begin
                hs_at_hold    = d_hs;
                qdata_at_hold = q_if.data;
            end
            q_if.ready = (k < hold) ? 1'b0 : ($urandom_range(99) < rp);
            if (mid && k == 3) begin
                start = 1; len = CW'(2);
            end else begin
                start = 0;
            end
            tick();
            k++;
        end
        if (k >= 600) chk("job_timeout", 64'(1), 64'(0));
        d_if.valid = 0;
        start = 0;
    endtask

    initial begin
        d_if.valid = 0; d_if.data = '0; d_if.strb = '0; q_if.ready = 0;
        #1 rst = 1;
        #2 check_reset_outputs("reset");
        tick(); tick();
        rst = 0;
        tick();

        // back-to-back job of 4 beats
        run_job(4, 100, 100, 0, 1, 0, 0);
        chk("t1_beats", 64'(obs_d.size()), 64'(4));
        for (int i = 0; i < 4 && i < obs_d.size(); i++) begin
            chk("t1_data", 64'(obs_d[i]), 64'(i + 1));
            chk("t1_cycle", 64'(obs_c[i]), 64'(start_cyc + 2 + i));
        end
        chk("t1_done_n", 64'(done_n), 64'(1));
        chk("t1_done_cyc", 64'(done_cyc), 64'(start_cyc + 6));
        chk("t1_cnt", 64'(cnt_at_done), 64'(4));
`ifdef MAC_MDC_COLLECTOR_CHECKSUM_EN
        chk("t1_csum", 64'(csum_at_done), 64'(4));
`endif

        // output stalled for 10 cycles
        run_job(8, 100, 100, 10, 1, 0, 0);
        chk("t2_accepts_in_stall", 64'(hs_at_hold), 64'(2));
        chk("t2_head_held", 64'(qdata_at_hold), 64'(1));
        chk("t2_beats", 64'(obs_d.size()), 64'(8));
        for (int i = 0; i < 8 && i < obs_d.size(); i++) chk("t2_data", 64'(obs_d[i]), 64'(i + 1));

        // zero-length job
        run_job(0, 100, 100, 0, 1, 0, 0);
        chk("t3_done_cyc", 64'(done_cyc), 64'(start_cyc + 1));
        chk("t3_beats", 64'(obs_d.size()), 64'(0));
        chk("t3_d_hs", 64'(d_hs), 64'(0));
        chk("t3_cnt", 64'(cnt_at_done), 64'(0));

        // start re-pulsed mid-job
        run_job(5, 100, 60, 0, 1, 1, 0);
        chk("t4_beats", 64'(obs_d.size()), 64'(5));
        chk("t4_cnt", 64'(cnt_at_done), 64'(5));
        chk("t4_done_n", 64'(done_n), 64'(1));

        // stray valid in idle
        wait_idle();
        d_if.valid = 1; d_if.data = 32'hdead_beef;
        tick(); tick(); tick();
        d_if.valid = 0;
        chk("t5_err_set", 64'(err), 64'(1));
        tick(); tick(); tick();
        chk("t5_err_sticky", 64'(err), 64'(1));
        clear = 1;
        tick();
        clear = 0;
        chk("t5_err_cleared", 64'(err), 64'(0));

        // asynchronous reset mid-job, then a fresh job
        run_job(6, 100, 100, 0, 1, 0, 3);
        run_job(2, 100, 100, 0, 1, 0, 0);
        chk("t6_beats", 64'(obs_d.size()), 64'(2));
        chk("t6_cnt", 64'(cnt_at_done), 64'(2));
        chk("t6_done_n", 64'(done_n), 64'(1));

        // randomized jobs
        for (int j = 0; j < 30; j++) begin
            int l;
            l = int'($urandom_range(9));
            run_job(l, int'($urandom_range(100, 30)), int'($urandom_range(100, 30)),
                    ($urandom_range(3) == 0) ? int'($urandom_range(6)) : 0, 0,
                    $urandom_range(3) == 0, 0);
            chk("rand_beats", 64'(obs_d.size()), 64'(l));
            chk("rand_done_n", 64'(done_n), 64'(1));
        end

        tick(); tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", tests, fails);
        $fatal(1);
    end
endmodule
